// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-port arbiter in front of a single SDRAM command/data interface.
//   Issues READ, WRITE and periodic REFRESH commands. Every command
//   lasts one cycle and NOP is driven in all other cycles.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   pN_req/we/addr/wdata        request from port N (level)
//   pN_gnt                      one-cycle pulse: command issued for port N
//   pN_rvalid/rdata             one-cycle read-data strobe, data held until next strobe
//   sdram_addr, sdram_data      command address, bidirectional data bus
//   sdram_cs_n/ras_n/cas_n/we_n command lines
//   busy                        high whenever the FSM is not IDLE
//
// Handshake: a requester raises req with we/addr/wdata and holds all of
//   them stable until it sees its one-cycle gnt. A req sampled high in IDLE
//   at the end of cycle R gets its command and gnt in cycle R+1. A req
//   dropped before it is sampled in IDLE is simply never served.
module sdram_arbiter #(
    parameter int ADDR_W           = 20,
    parameter int DATA_W           = 32,
    parameter int READ_LATENCY     = 2,
    parameter int REFRESH_INTERVAL = 390,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_data,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic              busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REF      = 3'd1;
    localparam logic [2:0] S_REF_WAIT = 3'd2;
    localparam logic [2:0] S_RD_CMD   = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_WR_CMD   = 3'd5;
    localparam logic [2:0] S_TURN     = 3'd6;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b1111;
    localparam logic [3:0] CMD_RD  = 4'b0001;
    localparam logic [3:0] CMD_WR  = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0011;

    localparam int WAIT_A   = (READ_LATENCY - 2 > REFRESH_CYCLES - 1) ? READ_LATENCY - 2 : REFRESH_CYCLES - 1;
    localparam int WAIT_MAX = (WAIT_A > 1) ? WAIT_A : 1;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int REF_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_INTERVAL - 1);

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [REF_W-1:0]  ref_cnt_q;
    logic              ref_pending_q;
    logic              ref_issue;
    logic              last_q, last_d;   // 1 = port 1 was granted last
    logic              port_q, port_d;   // port owning the current read
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oe_q, oe_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              pick0, pick1;

    // Round-robin only matters on a tie: port 0 wins unless it went last.
    assign pick0 = p0_req && (!p1_req || last_q);
    assign pick1 = p1_req && !pick0;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        last_d    = last_q;
        port_d    = port_q;
        cmd_d     = CMD_NOP;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        oe_d      = 1'b0;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rv0_d     = 1'b0;
        rv1_d     = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        ref_issue = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
                    state_d   = S_REF;
                    cmd_d     = CMD_REF;
                    ref_issue = 1'b1;
                end else if (pick0 || pick1) begin
                    port_d = pick1;
                    last_d = pick1;
                    gnt0_d = pick0;
                    gnt1_d = pick1;
                    addr_d = pick1 ? p1_addr : p0_addr;
                    if (pick1 ? p1_we : p0_we) begin
                        state_d = S_WR_CMD;
                        cmd_d   = CMD_WR;
                        wdata_d = pick1 ? p1_wdata : p0_wdata;
                        oe_d    = 1'b1;
                    end else begin
                        state_d = S_RD_CMD;
                        cmd_d   = CMD_RD;
                    end
                end
            end
            S_REF: begin
                state_d = S_REF_WAIT;
                wait_d  = WAIT_W'(REFRESH_CYCLES - 1);
            end
            S_REF_WAIT: begin
                if (wait_q == '0) state_d = S_IDLE;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_RD_CMD: begin
                // RD_WAIT spans READ_LATENCY-1 cycles; wait counts the extras.
                state_d = S_RD_WAIT;
                wait_d  = WAIT_W'(READ_LATENCY - 2);
            end
            S_RD_WAIT: begin
                if (wait_q == '0) begin
                    state_d = S_IDLE;
                    if (port_q) begin
                        rv1_d    = 1'b1;
                        rdata1_d = sdram_data;
                    end else begin
                        rv0_d    = 1'b1;
                        rdata0_d = sdram_data;
                    end
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_WR_CMD: state_d = S_TURN;
            S_TURN:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            last_q   <= 1'b1;
            port_q   <= 1'b0;
            cmd_q    <= CMD_NOP;
            addr_q   <= '0;
            wdata_q  <= '0;
            oe_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            last_q   <= last_d;
            port_q   <= port_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            oe_q     <= oe_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Free-running refresh timer. A wrap wins over a same-cycle clear so
    // that an interval elapsing exactly at issue time is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
        end else if (ref_cnt_q == REF_MAX) begin
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b1;
        end else begin
            ref_cnt_q <= ref_cnt_q + REF_W'(1);
            if (ref_issue) ref_pending_q <= 1'b0;
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
    assign sdram_addr = addr_q;
    assign sdram_data = oe_q ? wdata_q : {DATA_W{1'bz}};
    assign p0_gnt     = gnt0_q;
    assign p1_gnt     = gnt1_q;
    assign p0_rvalid  = rv0_q;
    assign p1_rvalid  = rv1_q;
    assign p0_rdata   = rdata0_q;
    assign p1_rdata   = rdata1_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Randomised bench for sdram_arbiter. A transaction-level scheduler model
//   predicts, per cycle, the command, grants, read strobes, read data and
//   busy. A small SDRAM memory model serves the bus.
module tb_sdram_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int RI = 16;
    localparam int RC = 4;

    localparam logic [3:0] NOP = 4'b1111;
    localparam logic [3:0] RD  = 4'b0001;
    localparam logic [3:0] WR  = 4'b0000;
    localparam logic [3:0] RF  = 4'b0011;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] sdram_addr;
    wire  [DW-1:0] sdram_data;
    logic sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, busy;

    logic          env_drv;
    logic [DW-1:0] env_word;
    assign sdram_data = env_drv ? env_word : {DW{1'bz}};

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL),
        .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .busy(busy)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    int n;                 // cycle index since reset release
    int free_at;           // first cycle the arbiter is IDLE again
    bit last_p;            // 1 = port 1 granted last
    bit pend;              // refresh owed
    logic [3:0]    exp_cmd[int];
    logic [1:0]    exp_gnt[int];
    logic [1:0]    exp_rv[int];
    logic [DW-1:0] exp_rd[int];
    logic [DW-1:0] exp_wd[int];
    logic [AW-1:0] exp_addr[int];
    logic [DW-1:0] hold[2];
    logic [DW-1:0] mdl_mem[int];
    logic [DW-1:0] env_mem[int];
    int            env_rd_cycle;
    logic [AW-1:0] env_rd_addr;
    txn_t q0[$];
    txn_t q1[$];
    bit   req_on[2];
    int   gap[2];
    int   gnt_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 5) return 32'h054585C5;
        return 32'h13579BDF ^ (32'(a) * 32'h01010111);
    endfunction

    function automatic logic [3:0] cmd_at(input int c);
        return exp_cmd.exists(c) ? exp_cmd[c] : NOP;
    endfunction

    function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        return t;
    endfunction

    // Scheduler model: in an idle cycle, decide what the next cycle holds.
    task automatic model_decide();
        int p;
        txn_t t;
        int a;
        p = -1;
        if (n > 0 && n % RI == 0) pend = 1'b1;
        if (n < free_at) return;
        if (pend) begin
            exp_cmd[n+1] = RF;
            pend = 1'b0;
            free_at = n + 2 + RC;
            return;
        end
        if (req_on[0] && req_on[1]) p = last_p ? 0 : 1;
        else if (req_on[0])         p = 0;
        else if (req_on[1])         p = 1;
        if (p < 0) return;
        t = (p == 1) ? q1[0] : q0[0];
        a = int'(t.addr);
        last_p = (p == 1);
        exp_gnt[n+1] = (p == 1) ? 2'b10 : 2'b01;
        exp_addr[n+1] = t.addr;
        if (t.we) begin
            exp_cmd[n+1] = WR;
            exp_wd[n+1] = t.wdata;
            mdl_mem[a] = t.wdata;
            free_at = n + 3;
        end else begin
            exp_cmd[n+1] = RD;
            exp_rv[n+1+RL] = (p == 1) ? 2'b10 : 2'b01;
            exp_rd[n+1+RL] = mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
            free_at = n + 1 + RL;
        end
    endtask

    task automatic drive_ports();
        p0_req = req_on[0];
        p1_req = req_on[1];
        if (req_on[0]) begin
            p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata;
        end
        if (req_on[1]) begin
            p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata;
        end
    endtask

    // Per-cycle work at the falling edge: check, memory, requesters, model.
    task automatic body();
        logic [3:0] cmd;
        logic [1:0] g;
        logic [1:0] r;
        cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
        g = exp_gnt.exists(n) ? exp_gnt[n] : 2'b00;
        r = exp_rv.exists(n) ? exp_rv[n] : 2'b00;
        check("cmd", 64'(cmd), 64'(cmd_at(n)));
        check("gnt", 64'({p1_gnt, p0_gnt}), 64'(g));
        check("rvalid", 64'({p1_rvalid, p0_rvalid}), 64'(r));
        check("gnt_excl", 64'(p0_gnt & p1_gnt), 64'(0));
        check("rv_excl", 64'(p0_rvalid & p1_rvalid), 64'(0));
        if (r[0]) hold[0] = exp_rd[n];
        if (r[1]) hold[1] = exp_rd[n];
        check("p0_rdata", 64'(p0_rdata), 64'(hold[0]));
        check("p1_rdata", 64'(p1_rdata), 64'(hold[1]));
        check("busy", 64'(busy), 64'(n < free_at));
        if (cmd_at(n) == RD || cmd_at(n) == WR)
            check("addr", 64'(sdram_addr), 64'(exp_addr[n]));
        if (cmd_at(n) == WR)
            check("wr_bus", 64'(sdram_data), 64'(exp_wd[n]));
        else if (env_drv)
            check("bus_hiz", 64'(sdram_data), 64'(env_word));
        if (p0_gnt) gnt_log.push_back(0);
        if (p1_gnt) gnt_log.push_back(1);

        // SDRAM memory model reacts to the commands actually on the bus.
        if (cmd == WR) env_mem[int'(sdram_addr)] = sdram_data;
        if (cmd == RD) begin
            env_rd_cycle = n + RL - 1;
            env_rd_addr = sdram_addr;
        end

        // Requesters: retire on grant, re-present after a random gap.
        if (g[0] && q0.size() > 0) begin void'(q0.pop_front()); req_on[0] = 1'b0; gap[0] = $urandom_range(0, 3); end
        if (g[1] && q1.size() > 0) begin void'(q1.pop_front()); req_on[1] = 1'b0; gap[1] = $urandom_range(0, 3); end
        for (int p = 0; p < 2; p++) begin
            if (!req_on[p] && ((p == 0) ? q0.size() : q1.size()) > 0) begin
                if (gap[p] > 0) gap[p]--;
                else            req_on[p] = 1'b1;
            end
        end
        drive_ports();
        model_decide();

        // Bus is released to the DUT around expected write cycles; otherwise
        // it carries read data or a random pattern that exposes DUT driving.
        env_drv = !(cmd_at(n) == WR || cmd_at(n+1) == WR);
        if (n == env_rd_cycle)
            env_word = env_mem.exists(int'(env_rd_addr)) ? env_mem[int'(env_rd_addr)] : init_word(int'(env_rd_addr));
        else
            env_word = $urandom();
    endtask

    task automatic tick();
        @(negedge clk);
        n++;
        body();
    endtask

    task automatic reset_and_release();
        rst_n = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        req_on[0] = 1'b0;
        req_on[1] = 1'b0;
        env_rd_cycle = -100;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        free_at = 0;
        last_p = 1'b1;
        pend = 1'b0;
        exp_cmd.delete(); exp_gnt.delete(); exp_rv.delete();
        exp_rd.delete(); exp_wd.delete(); exp_addr.delete();
        hold[0] = '0;
        hold[1] = '0;
        gap[0] = 0;
        gap[1] = 0;
        gnt_log.delete();
        body();
    endtask

    task automatic run_until_done(input int extra);
        int guard;
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0 || n < free_at) && guard < 3000) begin
            tick();
            guard++;
        end
        check("drain_timeout", 64'(guard >= 3000), 64'(0));
        repeat (extra) tick();
    endtask

    initial begin
        int guard;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        env_drv = 1'b1;
        env_word = '0;
        n = 0;

        // Single read from port 0.
        q0.push_back(mk(1'b0, 20'h00005, '0));
        reset_and_release();
        run_until_done(4);

        // Port 1 write then read-back.
        q1.push_back(mk(1'b1, 20'h00010, 32'hDEADBEEF));
        q1.push_back(mk(1'b0, 20'h00010, '0));
        reset_and_release();
        run_until_done(4);

        // Contention from reset release: grants must alternate from port 0.
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, AW'(i), '0));
            q1.push_back(mk(1'b0, AW'(i + 8), '0));
        end
        reset_and_release();
        run_until_done(4);
        check("rr_count", 64'(gnt_log.size() >= 4), 64'(1));
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check("rr_order", 64'(gnt_log[i]), 64'(i % 2));

        // Long random mix with refreshes interleaved.
        for (int i = 0; i < 60; i++) begin
            txn_t t;
            t = mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom());
            if ($urandom_range(0, 1) == 1) q1.push_back(t);
            else                           q0.push_back(t);
        end
        reset_and_release();
        run_until_done(20);

        // Reset asserted in the RD_WAIT cycle after a port 0 read grant.
        q0.push_back(mk(1'b0, 20'h00007, '0));
        reset_and_release();
        guard = 0;
        while (!(exp_gnt.exists(n) && exp_gnt[n][0]) && guard < 20) begin
            tick();
            guard++;
        end
        check("rst_gnt_seen", 64'(p0_gnt), 64'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_cmd", 64'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 64'(NOP));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_addr", 64'(sdram_addr), 64'(0));
        check("rst_bus", 64'(sdram_data), 64'(env_word));
        check("rst_gnt", 64'({p1_gnt, p0_gnt}), 64'(0));
        q0.delete();
        repeat (4) begin
            @(negedge clk);
            check("rst_no_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'(0));
        end
        q0.push_back(mk(1'b0, 20'h00005, '0));
        reset_and_release();
        run_until_done(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 20, word address width
- DATA_W, 32, SDRAM word width
- READ_LATENCY, 2, cycles from read command to rvalid (minimum 2)
- REFRESH_INTERVAL, 390, cycles between refresh requests
- REFRESH_CYCLES, 4, idle cycles after a refresh command
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_req, p1_req  in  1  port 0 or port 1 transaction request, level
- p0_we, p1_we  in  1  1=write, 0=read
- p0_addr, p1_addr  in  ADDR_W  word address
- p0_wdata, p1_wdata  in  DATA_W  write data
- p0_gnt, p1_gnt  out  1  one-cycle pulse: command issued for this port
- p0_rvalid, p1_rvalid  out  1  one-cycle pulse: read data valid
- p0_rdata, p1_rdata  out  DATA_W  read data, held until the next rvalid
- sdram_addr  out  ADDR_W  command address
- sdram_data  inout  DATA_W  bidirectional data bus
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1  command lines
- busy  out  1  high whenever the state is not IDLE

Function
REQ-003 Command encodings {cs_n,ras_n,cas_n,we_n} SHALL be: NOP=1111, READ=0001, WRITE=0000, REFRESH=0011. Each command SHALL be held for exactly one cycle; NOP SHALL be driven in all other cycles.
REQ-004 All SDRAM outputs and gnt/rvalid SHALL be registered.
REQ-005 sdram_data SHALL be driven with the write data only in WRITE command cycles. It SHALL be high-Z in every other cycle.
REQ-006 The FSM SHALL have the states IDLE, REF, REF_WAIT, RD_CMD, RD_WAIT, WR_CMD, TURN.
REQ-007 The refresh counter SHALL count every cycle from 0 to REFRESH_INTERVAL-1, then wrap to 0 and set ref_pending. ref_pending SHALL be cleared in the cycle the REFRESH command is issued.
REQ-008 In IDLE, the arbiter SHALL choose the next command in this order:
- ref_pending set: REF.
- Otherwise, exactly one req high: that port.
- Otherwise, both req high: the port not granted last (round-robin).
- Otherwise: remain in IDLE.
REQ-009 A request sampled high in IDLE in cycle R SHALL produce its command and its gnt pulse in cycle R+1. sdram_addr SHALL carry the address sampled in cycle R.
REQ-010 A requester SHALL hold req, we, addr and wdata stable until its gnt. A req dropped before it is sampled in IDLE SHALL issue no command.
REQ-011 Read with command in cycle C:
- C+1 .. C+READ_LATENCY-1: RD_WAIT.
- sdram_data captured at the rising edge ending cycle C+READ_LATENCY-1.
- Cycle C+READ_LATENCY: IDLE, with the granted port's rvalid high and rdata equal to the captured word.
REQ-012 Write with command in cycle C: C+1 is TURN (NOP, bus high-Z); C+2 is IDLE.
REQ-013 Refresh with command in cycle C: C+1 .. C+REFRESH_CYCLES is REF_WAIT; C+REFRESH_CYCLES+1 is IDLE.
REQ-014 A refresh becoming pending mid-transaction SHALL NOT abort that transaction. It SHALL be served at the next IDLE ahead of all requests.
REQ-015 The last-granted register SHALL update only on a port grant, not on a refresh.
REQ-016 gnt and rvalid SHALL never be high for both ports in the same cycle.

Reset
REQ-017 On rst_n low, immediately and regardless of clk, the block SHALL:
- Go to IDLE and drive NOP; sdram_addr=0; sdram_data high-Z.
- Clear all gnt/rvalid, rdata, busy and ref_pending.
- Set the refresh counter to 0 and the last-granted register to port 1, so port 0 wins the first tie.
REQ-018 Reset asserted mid-transaction SHALL discard that transaction with no rvalid afterwards. Requesters SHALL reissue after reset.
REQ-019 After rst_n rises, the first REFRESH SHALL occur REFRESH_INTERVAL cycles later, unless it is deferred by a transaction in progress.

Verification
REQ-020 Single read: p0 reads addr 0x00005 (memory 0x054585C5).
- p0_gnt one cycle after the request is sampled, with READ encoding and addr 0x00005.
- p0_rvalid exactly 2 cycles after gnt, with p0_rdata=0x054585C5.
REQ-021 Write then read-back: p1 writes 0xDEADBEEF to 0x00010, then reads 0x00010.
- sdram_data driven only in the WRITE cycle.
- One TURN cycle follows the write.
- Read-back returns 0xDEADBEEF on p1_rvalid.
REQ-022 Contention: p0 and p1 both hold read requests from reset release.
- Grants alternate p0, p1, p0, p1.
- gnt/rvalid never coincide across ports.
REQ-023 Refresh: with REFRESH_INTERVAL=16 and continuous p0 reads:
- A REFRESH (0011) is issued at the first IDLE after every 16-cycle wrap.
- No READ appears for 4 cycles after each REFRESH, and no read is lost.
REQ-024 Reset during RD_WAIT: assert rst_n low in the cycle after a p0 read gnt.
- Outputs go to NOP/high-Z without waiting for a clock edge.
- No p0_rvalid is seen.
- A new request after release completes normally.
